// File: rtl/crtc6845_if.sv
// crtc6845_if: CPU register port of the CRT controller (strobe, select, direction, write/read data).
// Latency: dout is combinational from the currently addressed register.
// Backpressure: none; every cs strobe is accepted.
interface crtc6845_if;
    logic       cs;
    logic       rs;
    logic       rw;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output cs, rs, rw, din, input dout);
    modport slave  (input cs, rs, rw, din, output dout);
endinterface

// File: rtl/crtc6845.sv
// crtc6845: HD6845S-style (type 0) CRT controller; optional light pen latch enabled by CRTC_LPEN_EN.
// Latency: video outputs registered, updated on the clk edge with cclk_en; register reads combinational.
// Backpressure: none; CPU strobes always accepted, counters frozen between cclk_en pulses.
module crtc6845 #(
    parameter int MA_W = 14,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            RESET_N,
    input  logic            cclk_en,
    crtc6845_if.slave       bus,
    output logic [MA_W-1:0] ma,
    output logic [RA_W-1:0] ra,
    output logic            hsync,
    output logic            vsync,
    output logic            de,
    output logic            cursor
`ifdef CRTC_LPEN_EN
    ,
    input  logic            lpen
`endif
);
    typedef enum logic {ST_NORMAL = 1'b0, ST_ADJ = 1'b1} vstate_e;

    vstate_e         state_q, state_d;
    logic [4:0]      addr_q, addr_d;
    logic [7:0]      r0_q, r0_d, r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
    logic [7:0]      r8_q, r8_d, r13_q, r13_d, r15_q, r15_d;
    logic [6:0]      r4_q, r4_d, r6_q, r6_d, r7_q, r7_d, r10_q, r10_d;
    logic [4:0]      r5_q, r5_d, r9_q, r9_d, r11_q, r11_d;
    logic [5:0]      r12_q, r12_d, r14_q, r14_d;
    logic [7:0]      hcc_q, hcc_d;
    logic [6:0]      vcc_q, vcc_d;
    logic [4:0]      rc_q, rc_d, vadj_q, vadj_d;
    logic [3:0]      hsw_q, hsw_d, vsw_q, vsw_d;
    logic [13:0]     line_base_q, line_base_d, next_base_q, next_base_d;
    logic [MA_W-1:0] ma_q, ma_d;
    logic            hde_q, hde_d, vde_q, vde_d;
    logic            hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, cursor_q, cursor_d;
    logic            eol, row_end, new_frame;
    logic [13:0]     lin_addr;
    logic [7:0]      rd_dat;
    logic            unused_bits;
`ifdef CRTC_LPEN_EN
    logic [5:0]      r16_q, r16_d;
    logic [7:0]      r17_q, r17_d;
    logic            lpen_q, lpen_d;
    logic [13:0]     lp_ma;
    assign lp_ma = 14'(ma_q);
`endif

    always_comb begin
        state_d = state_q;   addr_d = addr_q;
        r0_d = r0_q;   r1_d = r1_q;   r2_d = r2_q;   r3_d = r3_q;   r4_d = r4_q;
        r5_d = r5_q;   r6_d = r6_q;   r7_d = r7_q;   r8_d = r8_q;   r9_d = r9_q;
        r10_d = r10_q; r11_d = r11_q; r12_d = r12_q; r13_d = r13_q; r14_d = r14_q; r15_d = r15_q;
        hcc_d = hcc_q; vcc_d = vcc_q; rc_d = rc_q;   vadj_d = vadj_q;
        hsw_d = hsw_q; vsw_d = vsw_q;
        line_base_d = line_base_q;   next_base_d = next_base_q;   ma_d = ma_q;
        hde_d = hde_q; vde_d = vde_q; hsync_d = hsync_q; vsync_d = vsync_q;
        de_d = de_q;   cursor_d = cursor_q;
        eol = 1'b0;    row_end = 1'b0; new_frame = 1'b0; lin_addr = '0;
`ifdef CRTC_LPEN_EN
        r16_d = r16_q; r17_d = r17_q; lpen_d = lpen;
        if (lpen && !lpen_q) begin
            r16_d = lp_ma[13:8];
            r17_d = lp_ma[7:0];
        end
`endif

        if (bus.cs && !bus.rs) addr_d = bus.din[4:0];
        // R16/R17 are light-pen captures and never CPU-writable
        if (bus.cs && bus.rs && !bus.rw) begin
            case (addr_q)
                5'd0:    r0_d  = bus.din;
                5'd1:    r1_d  = bus.din;
                5'd2:    r2_d  = bus.din;
                5'd3:    r3_d  = bus.din;
                5'd4:    r4_d  = bus.din[6:0];
                5'd5:    r5_d  = bus.din[4:0];
                5'd6:    r6_d  = bus.din[6:0];
                5'd7:    r7_d  = bus.din[6:0];
                5'd8:    r8_d  = bus.din;
                5'd9:    r9_d  = bus.din[4:0];
                5'd10:   r10_d = bus.din[6:0];
                5'd11:   r11_d = bus.din[4:0];
                5'd12:   r12_d = bus.din[5:0];
                5'd13:   r13_d = bus.din;
                5'd14:   r14_d = bus.din[5:0];
                5'd15:   r15_d = bus.din;
                default: ;
            endcase
        end

        if (cclk_en) begin
            eol   = (hcc_q == r0_q);
            hcc_d = eol ? 8'd0 : hcc_q + 8'd1;
            if (eol) begin
                if (state_q == ST_ADJ) begin
                    if (vadj_q == r5_q - 5'd1) begin
                        new_frame = 1'b1;
                    end else begin
                        vadj_d = vadj_q + 5'd1;
                        rc_d   = rc_q + 5'd1;
                    end
                end else if (rc_q == r9_q) begin
                    row_end = 1'b1;
                    rc_d    = 5'd0;
                    if (vcc_q == r4_q) begin
                        if (r5_q == 5'd0) begin
                            new_frame = 1'b1;
                        end else begin
                            // adjust lines keep counting raster past R9
                            state_d = ST_ADJ;
                            vadj_d  = 5'd0;
                            rc_d    = rc_q + 5'd1;
                        end
                    end else begin
                        vcc_d = vcc_q + 7'd1;
                    end
                end else begin
                    rc_d = rc_q + 5'd1;
                end
                if (row_end) line_base_d = next_base_q;
                if (new_frame) begin
                    vcc_d       = 7'd0;
                    rc_d        = 5'd0;
                    state_d     = ST_NORMAL;
                    line_base_d = {r12_q, r13_q};
                    vde_d       = 1'b1;
                end
                if (state_d == ST_NORMAL && rc_d == 5'd0 && vcc_d == r6_q) vde_d = 1'b0;
                if (vsync_q) begin
                    vsw_d = vsw_q + 4'd1;
                    if (vsw_d == r3_q[7:4]) vsync_d = 1'b0;
                end else if (state_d == ST_NORMAL && rc_d == 5'd0 && vcc_d == r7_q) begin
                    vsync_d = 1'b1;
                    vsw_d   = 4'd0;
                end
            end

            lin_addr = line_base_d + {6'd0, hcc_d};
            ma_d     = MA_W'(lin_addr);
            if (hcc_d == r1_q && rc_d == r9_q) next_base_d = lin_addr;

            // clear wins so that R1 = 0 keeps the line blank
            if (hcc_d == r1_q)      hde_d = 1'b0;
            else if (hcc_d == 8'd0) hde_d = 1'b1;

            if (hsync_q) begin
                if (hsw_q >= r3_q[3:0]) hsync_d = 1'b0;
                else                    hsw_d   = hsw_q + 4'd1;
            end else if (hcc_d == r2_q && r3_q[3:0] != 4'd0) begin
                hsync_d = 1'b1;
                hsw_d   = 4'd1;
            end

            de_d     = hde_d & vde_d;
            cursor_d = de_d && (ma_d == MA_W'({r14_q, r15_q}))
                       && (rc_d >= r10_q[4:0]) && (rc_d <= r11_q);
        end
    end

    always_comb begin
        rd_dat = 8'h00;
        case (addr_q)
            5'd14:   rd_dat = {2'b00, r14_q};
            5'd15:   rd_dat = r15_q;
`ifdef CRTC_LPEN_EN
            5'd16:   rd_dat = {2'b00, r16_q};
            5'd17:   rd_dat = r17_q;
`endif
            default: rd_dat = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_NORMAL; addr_q <= '0;
            r0_q <= '0;  r1_q <= '0;  r2_q <= '0;  r3_q <= '0;  r4_q <= '0;  r5_q <= '0;
            r6_q <= '0;  r7_q <= '0;  r8_q <= '0;  r9_q <= '0;  r10_q <= '0; r11_q <= '0;
            r12_q <= '0; r13_q <= '0; r14_q <= '0; r15_q <= '0;
            hcc_q <= '0; vcc_q <= '0; rc_q <= '0;  vadj_q <= '0; hsw_q <= '0; vsw_q <= '0;
            line_base_q <= '0; next_base_q <= '0; ma_q <= '0;
            hde_q <= 1'b0;   vde_q <= 1'b0;   hsync_q <= 1'b0; vsync_q <= 1'b0;
            de_q <= 1'b0;    cursor_q <= 1'b0;
`ifdef CRTC_LPEN_EN
            r16_q <= '0; r17_q <= '0; lpen_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d; addr_q <= addr_d;
            r0_q <= r0_d;   r1_q <= r1_d;   r2_q <= r2_d;   r3_q <= r3_d;   r4_q <= r4_d;
            r5_q <= r5_d;   r6_q <= r6_d;   r7_q <= r7_d;   r8_q <= r8_d;   r9_q <= r9_d;
            r10_q <= r10_d; r11_q <= r11_d; r12_q <= r12_d; r13_q <= r13_d;
            r14_q <= r14_d; r15_q <= r15_d;
            hcc_q <= hcc_d; vcc_q <= vcc_d; rc_q <= rc_d; vadj_q <= vadj_d;
            hsw_q <= hsw_d; vsw_q <= vsw_d;
            line_base_q <= line_base_d; next_base_q <= next_base_d; ma_q <= ma_d;
            hde_q <= hde_d;     vde_q <= vde_d;     hsync_q <= hsync_d; vsync_q <= vsync_d;
            de_q <= de_d;       cursor_q <= cursor_d;
`ifdef CRTC_LPEN_EN
            r16_q <= r16_d; r17_q <= r17_d; lpen_q <= lpen_d;
`endif
        end
    end

    // R8 and the blink-mode bits are stored for software but drive nothing here
    assign unused_bits = ^{r8_q, r10_q[6:5]};

    assign bus.dout = rd_dat;
    assign ma       = ma_q;
    assign ra       = RA_W'(rc_q);
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign de       = de_q;
    assign cursor   = cursor_q;
endmodule

// File: tb/tb_crtc6845.sv
// tb_crtc6845: directed checks of CRTC frame/line timing, addressing, sync widths, cursor, register port and reset.
module tb_crtc6845;
    logic        clk = 1'b0;
    logic        RESET_N;
    logic        cclk_en;
    logic [13:0] ma;
    logic [4:0]  ra;
    logic        hsync, vsync, de, cursor;
`ifdef CRTC_LPEN_EN
    logic        lpen = 1'b0;
`endif

    crtc6845_if bus();

    int n_vec = 0;
    int n_err = 0;
    int k     = 0;
    bit slow  = 1'b0;

    crtc6845 #(.MA_W(14), .RA_W(5)) dut (
        .clk     (clk),
        .RESET_N (RESET_N),
        .cclk_en (cclk_en),
        .bus     (bus),
        .ma      (ma),
        .ra      (ra),
        .hsync   (hsync),
        .vsync   (vsync),
        .de      (de),
        .cursor  (cursor)
`ifdef CRTC_LPEN_EN
        ,
        .lpen    (lpen)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (char %0d)", tag, got, exp, k);
        end
    endtask

    // one character; fast mode holds cclk_en high, slow mode pulses it once per 16 clk
    task automatic adv();
        cclk_en = 1'b1;
        @(negedge clk);
        k++;
        if (slow) begin
            cclk_en = 1'b0;
            repeat (15) @(negedge clk);
        end
    endtask

    task automatic run_to(input int target);
        while (k < target) adv();
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [7:0] d);
        cclk_en = 1'b0;
        bus.cs = 1'b1; bus.rs = 1'b0; bus.rw = 1'b0; bus.din = {3'b000, a};
        @(negedge clk);
        bus.rs = 1'b1; bus.din = d;
        @(negedge clk);
        bus.cs = 1'b0; bus.rs = 1'b0;
    endtask

    task automatic sel_reg(input logic [4:0] a);
        cclk_en = 1'b0;
        bus.cs = 1'b1; bus.rs = 1'b0; bus.rw = 1'b0; bus.din = {3'b000, a};
        @(negedge clk);
        bus.cs = 1'b0; bus.rs = 1'b1; bus.rw = 1'b1;
    endtask

    initial begin
        int vs1, kf, cnt, first, last, hs_cnt, hs_first;
        logic [13:0] cap;
        bit found;

        RESET_N = 1'b0; cclk_en = 1'b0;
        bus.cs = 1'b0; bus.rs = 1'b0; bus.rw = 1'b0; bus.din = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ma", 32'(ma), 32'h0);
        check("rst_ra", 32'(ra), 32'h0);
        check("rst_flags", 32'({hsync, vsync, de, cursor}), 32'h0);
        RESET_N = 1'b1;
        @(negedge clk);

        wr_reg(0, 63);  wr_reg(1, 40);  wr_reg(2, 46);  wr_reg(3, 8'h8E);
        wr_reg(4, 38);  wr_reg(5, 0);   wr_reg(6, 25);  wr_reg(7, 30);
        wr_reg(9, 7);   wr_reg(10, 0);  wr_reg(11, 7);  wr_reg(12, 8'h30);
        wr_reg(13, 0);  wr_reg(14, 8'h31); wr_reg(15, 8'h05);
        sel_reg(14); check("rd_r14", 32'(bus.dout), 32'h31);
        sel_reg(15); check("rd_r15", 32'(bus.dout), 32'h05);
        sel_reg(12); check("rd_r12", 32'(bus.dout), 32'h00);

        // first vsync of the partial frame after reset: vcc 30, rc 0
        found = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            adv();
            if (vsync) begin found = 1'b1; break; end
        end
        check("vs1_seen", 32'(found), 32'h1);
        check("vs1_char", k, 15360);
        vs1 = k;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            adv();
            if (!vsync) begin found = 1'b1; break; end
        end
        check("vs1_fall_seen", 32'(found), 32'h1);
        check("vs_width_8", k - vs1, 512);

        found = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            adv();
            if (ma == 14'h3000) begin found = 1'b1; break; end
        end
        check("frame_seen", 32'(found), 32'h1);
        check("frame_char", k, 19968);
        check("frame_ra", 32'(ra), 32'h0);
        check("frame_de", 32'(de), 32'h1);
        kf = k;

        cnt = 0; last = -1; hs_cnt = 0; hs_first = -1; cap = '0;
        for (int h = 0; h < 64; h++) begin
            if (h > 0) adv();
            if (de) begin cnt++; last = h; end
            if (hsync) begin hs_cnt++; if (hs_first < 0) hs_first = h; end
            if (h == 39) cap = ma;
        end
        check("line_de_cnt", cnt, 40);
        check("line_de_last", last, 39);
        check("line_hs_first", hs_first, 46);
        check("line_hs_width", hs_cnt, 14);
        check("line_ma_h39", 32'(cap), 32'h3027);
        adv();
        check("row0_line1_ma", 32'(ma), 32'h3000);
        check("row0_line1_ra", 32'(ra), 32'h1);
        run_to(kf + 512);
        check("row1_ma", 32'(ma), 32'h3028);
        check("row1_ra", 32'(ra), 32'h0);

        run_to(kf + 6 * 512);
        cnt = 0; first = -1; cap = '0;
        for (int i = 0; i < 512; i++) begin
            if (i > 0) adv();
            if (cursor) begin cnt++; if (first < 0) begin first = i; cap = ma; end end
        end
        check("cursor_cnt", cnt, 8);
        check("cursor_ma", 32'(cap), 32'h3105);

        run_to(kf + 24 * 512);
        check("row24_ma", 32'(ma), 32'h33C0);
        check("row24_de", 32'(de), 32'h1);
        run_to(kf + 25 * 512);
        check("row25_ma", 32'(ma), 32'h33E8);
        check("row25_de", 32'(de), 32'h0);

        wr_reg(3, 8'h0E);
        found = 1'b0; cnt = 0;
        for (int i = 0; i < 4000; i++) begin
            adv();
            if (de) cnt++;
            if (vsync) begin found = 1'b1; break; end
        end
        check("vs2_seen", 32'(found), 32'h1);
        check("vs_period", k - vs1, 19968);
        check("blank_rows_de", cnt, 0);
        vs1 = k;

        wr_reg(5, 2);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            adv();
            if (!vsync) begin found = 1'b1; break; end
        end
        check("vs2_fall_seen", 32'(found), 32'h1);
        check("vs_width_16", k - vs1, 1024);

        run_to(kf + 19968);
        check("adj0_ra", 32'(ra), 32'h8);
        check("adj0_ma", 32'(ma), 32'h3618);
        check("adj0_de", 32'(de), 32'h0);
        run_to(kf + 19968 + 64);
        check("adj1_ra", 32'(ra), 32'h9);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            adv();
            if (ma == 14'h3000) begin found = 1'b1; break; end
        end
        check("adj_frame_seen", 32'(found), 32'h1);
        check("adj_frame_len", k - kf, 20096);
        check("adj_frame_ra", 32'(ra), 32'h0);

        slow = 1'b1;
        adv(); adv(); adv();
        check("slow_ma", 32'(ma), 32'h3003);
        check("slow_de", 32'(de), 32'h1);
        slow = 1'b0;
        cclk_en = 1'b0;

        #2 RESET_N = 1'b0;
        #1;
        check("async_rst_ma", 32'(ma), 32'h0);
        check("async_rst_flags", 32'({hsync, vsync, de, cursor}), 32'h0);
        @(negedge clk);
        RESET_N = 1'b1;
        @(negedge clk);
        sel_reg(14);
        check("rst_r14", 32'(bus.dout), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
